// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode patterns, control encodings and stage control structs
// for the pipelined LEGv8 control unit.
package pipe_ctrl_pkg;
    localparam int RD_W = 5;

    localparam logic [10:0] M_OP6   = 11'b11111100000;
    localparam logic [10:0] M_OP8   = 11'b11111111000;
    localparam logic [10:0] M_OP10  = 11'b11111111110;
    localparam logic [10:0] M_OP11  = 11'b11111111111;
    localparam logic [10:0] V_B     = 11'b00010100000;
    localparam logic [10:0] V_BL    = 11'b10010100000;
    localparam logic [10:0] V_BLT   = 11'b01010100000;
    localparam logic [10:0] V_CBZ   = 11'b10110100000;
    localparam logic [10:0] V_BR    = 11'b11010110000;
    localparam logic [10:0] V_ADDI  = 11'b10010001000;
    localparam logic [10:0] V_ADDS  = 11'b10101011000;
    localparam logic [10:0] V_SUBS  = 11'b11101011000;
    localparam logic [10:0] V_LDUR  = 11'b11111000010;
    localparam logic [10:0] V_STUR  = 11'b11111000000;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;

    localparam logic [1:0] SRC_REG   = 2'b00;
    localparam logic [1:0] SRC_IMM   = 2'b01;
    localparam logic [1:0] SRC_DADDR = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    typedef enum logic [3:0] {
        OP_NOP, OP_B, OP_BL, OP_BLT, OP_CBZ, OP_BR,
        OP_ADDI, OP_ADDS, OP_SUBS, OP_LDUR, OP_STUR, OP_ILL
    } op_e;

    typedef struct packed {
        logic [2:0]      alu_op;
        logic [1:0]      alu_src;
        logic            flag_write;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic [1:0]      mem2reg;
        logic [RD_W-1:0] rd;
        logic            is_load;
    } ctrl_t;

    typedef struct packed {
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic [1:0]      mem2reg;
        logic [RD_W-1:0] rd;
        logic            is_load;
    } mem_ctrl_t;

    typedef struct packed {
        logic            reg_write;
        logic [1:0]      mem2reg;
        logic [RD_W-1:0] rd;
    } wb_ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    function automatic op_e classify(input logic [10:0] opc);
        if ((opc & M_OP6) == V_B) return OP_B;
        if ((opc & M_OP6) == V_BL) return OP_BL;
        if ((opc & M_OP8) == V_BLT) return OP_BLT;
        if ((opc & M_OP8) == V_CBZ) return OP_CBZ;
        if ((opc & M_OP11) == V_BR) return OP_BR;
        if ((opc & M_OP10) == V_ADDI) return OP_ADDI;
        if ((opc & M_OP11) == V_ADDS) return OP_ADDS;
        if ((opc & M_OP11) == V_SUBS) return OP_SUBS;
        if ((opc & M_OP11) == V_LDUR) return OP_LDUR;
        if ((opc & M_OP11) == V_STUR) return OP_STUR;
        return OP_ILL;
    endfunction
endpackage

// File: rtl/pipelined_control_if.sv
// pipelined_control_if: ID-stage inputs and per-stage control outputs of the
// pipelined control unit.
interface pipelined_control_if #(parameter int REG_AW = 5);
    logic [31:0]       instr_id;
    logic              instr_valid;
    logic              rt_is_zero;
    logic              alu_n;
    logic              alu_v;
    logic              id_br_taken;
    logic              id_br_src;
    logic              id_uncond_br;
    logic              id_reg2loc;
    logic              stall;
    logic              flush_if;
    logic              illegal_op;
    logic [2:0]        ex_alu_op;
    logic [1:0]        ex_alu_src;
    logic              ex_flag_write;
    logic              ex_reg_write;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_mem_write;
    logic              mem_mem_read;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_reg_write;
    logic [1:0]        wb_mem2reg;
    logic [REG_AW-1:0] wb_rd;
    logic              flag_n_q;
    logic              flag_v_q;

    modport master (
        output instr_id, instr_valid, rt_is_zero, alu_n, alu_v,
        input  id_br_taken, id_br_src, id_uncond_br, id_reg2loc, stall, flush_if, illegal_op,
        input  ex_alu_op, ex_alu_src, ex_flag_write, ex_reg_write, ex_rd,
        input  mem_mem_write, mem_mem_read, mem_reg_write, mem_rd,
        input  wb_reg_write, wb_mem2reg, wb_rd, flag_n_q, flag_v_q
    );
    modport slave (
        input  instr_id, instr_valid, rt_is_zero, alu_n, alu_v,
        output id_br_taken, id_br_src, id_uncond_br, id_reg2loc, stall, flush_if, illegal_op,
        output ex_alu_op, ex_alu_src, ex_flag_write, ex_reg_write, ex_rd,
        output mem_mem_write, mem_mem_read, mem_reg_write, mem_rd,
        output wb_reg_write, wb_mem2reg, wb_rd, flag_n_q, flag_v_q
    );
endinterface

// File: rtl/pipelined_control_hazard_detect.sv
// hazard_detect: stalls for load-use and for CBZ/BR operands that forwarding
// cannot deliver to ID in time.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int ZERO_REG = 31
) (
    input  logic            reset,
    input  logic            id_cbr,
    input  logic            use_rn,
    input  logic            use_rm,
    input  logic            use_rt,
    input  logic [RD_W-1:0] rn,
    input  logic [RD_W-1:0] rm,
    input  logic [RD_W-1:0] rt,
    input  logic            ex_is_load,
    input  logic            ex_reg_write,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            mem_is_load,
    input  logic [RD_W-1:0] mem_rd,
    output logic            stall
);
    function automatic logic hit(input logic [RD_W-1:0] src, input logic [RD_W-1:0] dst);
        return src == dst && src != RD_W'(ZERO_REG);
    endfunction

    logic load_use, cbr_ex, cbr_mem;

    always_comb begin
        load_use = ex_is_load & ((use_rn & hit(rn, ex_rd)) | (use_rm & hit(rm, ex_rd)) | (use_rt & hit(rt, ex_rd)));
        cbr_ex   = id_cbr & ex_reg_write & hit(rt, ex_rd);
        cbr_mem  = id_cbr & mem_is_load & hit(rt, mem_rd);
        stall    = !reset & (load_use | cbr_ex | cbr_mem);
    end
endmodule

// File: rtl/pipelined_control.sv
// pipelined_control: LEGv8 5-stage control unit -- ID decode and branch
// resolution, ID/EX..MEM/WB control registers, hazard stall and N/V flags.
module pipelined_control
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DELAY_SLOT = 1,
    parameter int LINK_REG   = 30,
    parameter int ZERO_REG   = 31
) (
    input logic               clk,
    input logic               reset,
    pipelined_control_if.slave bus
);
    op_e             op;
    ctrl_t           id_ctrl, id_ex;
    mem_ctrl_t       ex_mem;
    wb_ctrl_t        mem_wb;
    logic [RD_W-1:0] rn, rm, rt;
    logic            use_rn, use_rm, use_rt, is_cbr, stall, blt_nv, taken_raw, flag_n, flag_v;

    assign op = bus.instr_valid ? classify(bus.instr_id[31:21]) : OP_NOP;
    assign rn = bus.instr_id[9:5];
    assign rm = bus.instr_id[20:16];
    assign rt = bus.instr_id[4:0];

    always_comb begin
        id_ctrl = BUBBLE;
        case (op)
            OP_BL:   begin id_ctrl.reg_write = 1'b1; id_ctrl.mem2reg = M2R_PC4; id_ctrl.rd = RD_W'(LINK_REG); end
            OP_ADDI: begin id_ctrl.alu_op = ALU_ADD; id_ctrl.alu_src = SRC_IMM; id_ctrl.reg_write = 1'b1; id_ctrl.rd = rt; end
            OP_ADDS: begin id_ctrl.alu_op = ALU_ADD; id_ctrl.flag_write = 1'b1; id_ctrl.reg_write = 1'b1; id_ctrl.rd = rt; end
            OP_SUBS: begin id_ctrl.alu_op = ALU_SUB; id_ctrl.flag_write = 1'b1; id_ctrl.reg_write = 1'b1; id_ctrl.rd = rt; end
            OP_LDUR: begin
                id_ctrl.alu_op = ALU_ADD; id_ctrl.alu_src = SRC_DADDR; id_ctrl.mem_read = 1'b1;
                id_ctrl.reg_write = 1'b1; id_ctrl.mem2reg = M2R_MEM; id_ctrl.rd = rt; id_ctrl.is_load = 1'b1;
            end
            OP_STUR: begin id_ctrl.alu_op = ALU_ADD; id_ctrl.alu_src = SRC_DADDR; id_ctrl.mem_write = 1'b1; end
            default: id_ctrl.alu_op = ALU_PASSB;
        endcase
    end

    assign use_rn = op inside {OP_ADDS, OP_SUBS, OP_ADDI, OP_LDUR, OP_STUR};
    assign use_rm = op inside {OP_ADDS, OP_SUBS};
    assign use_rt = op inside {OP_STUR, OP_CBZ, OP_BR};
    assign is_cbr = op inside {OP_CBZ, OP_BR};

    hazard_detect #(.ZERO_REG(ZERO_REG)) u_hazard (
        .reset(reset), .id_cbr(is_cbr), .use_rn(use_rn), .use_rm(use_rm), .use_rt(use_rt),
        .rn(rn), .rm(rm), .rt(rt),
        .ex_is_load(id_ex.is_load), .ex_reg_write(id_ex.reg_write), .ex_rd(id_ex.rd),
        .mem_is_load(ex_mem.is_load), .mem_rd(ex_mem.rd), .stall(stall)
    );

    // BLT sees the flags of an ALU op still in EX before they are registered
    assign blt_nv    = id_ex.flag_write ? bus.alu_n ^ bus.alu_v : flag_n ^ flag_v;
    assign taken_raw = (op inside {OP_B, OP_BL, OP_BR}) | (op == OP_CBZ & bus.rt_is_zero) | (op == OP_BLT & blt_nv);

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex  <= BUBBLE;
            ex_mem <= '0;
            mem_wb <= '0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            id_ex  <= stall ? BUBBLE : id_ctrl;
            ex_mem <= '{id_ex.mem_read, id_ex.mem_write, id_ex.reg_write, id_ex.mem2reg, id_ex.rd, id_ex.is_load};
            mem_wb <= '{ex_mem.reg_write, ex_mem.mem2reg, ex_mem.rd};
            if (id_ex.flag_write) begin
                flag_n <= bus.alu_n;
                flag_v <= bus.alu_v;
            end
        end
    end

    assign bus.stall         = stall;
    assign bus.id_br_taken   = taken_raw & !stall;
    assign bus.flush_if      = taken_raw & !stall & (DELAY_SLOT == 0);
    assign bus.id_br_src     = op == OP_BR;
    assign bus.id_uncond_br  = op inside {OP_B, OP_BL};
    assign bus.id_reg2loc    = op inside {OP_ADDS, OP_SUBS};
    assign bus.illegal_op    = op == OP_ILL;
    assign bus.ex_alu_op     = id_ex.alu_op;
    assign bus.ex_alu_src    = id_ex.alu_src;
    assign bus.ex_flag_write = id_ex.flag_write;
    assign bus.ex_reg_write  = id_ex.reg_write;
    assign bus.ex_rd         = REG_AW'(id_ex.rd);
    assign bus.mem_mem_write = ex_mem.mem_write;
    assign bus.mem_mem_read  = ex_mem.mem_read;
    assign bus.mem_reg_write = ex_mem.reg_write;
    assign bus.mem_rd        = REG_AW'(ex_mem.rd);
    assign bus.wb_reg_write  = mem_wb.reg_write;
    assign bus.wb_mem2reg    = mem_wb.mem2reg;
    assign bus.wb_rd         = REG_AW'(mem_wb.rd);
    assign bus.flag_n_q      = flag_n;
    assign bus.flag_v_q      = flag_v;
endmodule
